// File: rtl/dp_run_sequencer_if.sv
// Memory-side bundle of the dot-product run sequencer: operand memory read
// port plus the datapath control/operand/result signals.
interface dp_run_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_BITS  = 10
);
  // operand memories (shared address, synchronous read)
  logic                  MEM_RD_EN;
  logic [ADDR_BITS-1:0]  MEM_ADDR;
  logic [7:0]            MEM_A_RDATA;
  logic [7:0]            MEM_B_RDATA;

  // dot-product datapath
  logic                  DP_ARESETN;
  logic [7:0]            DP_A;
  logic [7:0]            DP_B;
  logic                  DP_INPUTS_READY;
  logic [DATA_WIDTH-1:0] DP_VECTOR_LENGTH;
  logic                  DP_START;
  logic [DATA_WIDTH-1:0] DP_RESULT;
  logic                  DP_DONE;

  // sequencer side
  modport master (
    output MEM_RD_EN, MEM_ADDR,
    input  MEM_A_RDATA, MEM_B_RDATA,
    output DP_ARESETN, DP_A, DP_B, DP_INPUTS_READY, DP_VECTOR_LENGTH, DP_START,
    input  DP_RESULT, DP_DONE
  );

  // memories + datapath side
  modport slave (
    input  MEM_RD_EN, MEM_ADDR,
    output MEM_A_RDATA, MEM_B_RDATA,
    input  DP_ARESETN, DP_A, DP_B, DP_INPUTS_READY, DP_VECTOR_LENGTH, DP_START,
    output DP_RESULT, DP_DONE
  );
endinterface

// File: rtl/dp_run_sequencer.sv
// Command-level controller for the 8-bit dot-product datapath: clears the
// datapath, streams operand pairs from the element memories with one
// inputs_ready strobe per pair, then enables completion and returns the result.
module dp_run_sequencer #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_BITS      = 10,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  CMD_START,
  input  logic [DATA_WIDTH-1:0] CMD_LENGTH,
  input  logic                  CMD_ABORT,
  output logic                  CMD_BUSY,
  output logic                  CMD_DONE,
  output logic                  CMD_ERROR,
  output logic [DATA_WIDTH-1:0] CMD_RESULT,
  dp_run_sequencer_if.master    bus
);

  localparam int IDX_W  = ADDR_BITS + 1;
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DATA_WIDTH-1:0] MAX_LEN = DATA_WIDTH'(64'd1 << ADDR_BITS);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLEAR0,
    S_CLEAR1,
    S_FETCH,
    S_LOAD,
    S_STROBE,
    S_GAP,
    S_WAIT_DONE,
    S_FINISH
  } state_t;

  state_t                r_state;
  state_t                w_next_state;

  logic [IDX_W-1:0]      r_index;
  logic [DATA_WIDTH-1:0] r_len;
  logic [WAIT_W-1:0]     r_wait_cnt;
  logic [7:0]            r_dp_a;
  logic [7:0]            r_dp_b;
  logic [DATA_WIDTH-1:0] r_result;
  logic                  r_error;
  logic                  r_abort_clr;
  logic                  r_rst_hold;

  logic                  w_in_run;
  logic                  w_last;
  logic                  w_timeout;
  logic                  w_start_run;
  logic                  w_start_short;
  logic                  w_short_err;
  logic                  w_idx_inc;
  logic                  w_capture;
  logic                  w_fail;
  logic                  w_abort;

  // abortable window is CLEAR0 through WAIT_DONE
  assign w_in_run = (r_state == S_CLEAR0) || (r_state == S_CLEAR1) ||
                    (r_state == S_FETCH)  || (r_state == S_LOAD)   ||
                    (r_state == S_STROBE) || (r_state == S_GAP)    ||
                    (r_state == S_WAIT_DONE);

  // index is one bit wider than the address so length 2^ADDR_BITS compares correctly
  assign w_last    = (DATA_WIDTH'(r_index) == (r_len - DATA_WIDTH'(1)));
  // counter is 0 in the first WAIT_DONE cycle, so this fires on the last allowed cycle
  assign w_timeout = (r_wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1));

  // state register
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // next-state logic and per-cycle control decisions
  always_comb begin
    w_next_state  = r_state;
    w_start_run   = 1'b0;
    w_start_short = 1'b0;
    w_short_err   = 1'b0;
    w_idx_inc     = 1'b0;
    w_capture     = 1'b0;
    w_fail        = 1'b0;
    w_abort       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (CMD_START) begin
          if (CMD_LENGTH == '0) begin
            w_start_short = 1'b1;
            w_next_state  = S_FINISH;
          end else if (CMD_LENGTH > MAX_LEN) begin
            w_start_short = 1'b1;
            w_short_err   = 1'b1;
            w_next_state  = S_FINISH;
          end else begin
            w_start_run   = 1'b1;
            w_next_state  = S_CLEAR0;
          end
        end
      end
      S_CLEAR0: w_next_state = S_CLEAR1;
      S_CLEAR1: w_next_state = S_FETCH;
      S_FETCH:  w_next_state = S_LOAD;
      S_LOAD:   w_next_state = S_STROBE;
      S_STROBE: w_next_state = S_GAP;
      S_GAP: begin
        if (w_last) begin
          w_next_state = S_WAIT_DONE;
        end else begin
          w_idx_inc    = 1'b1;
          w_next_state = S_FETCH;
        end
      end
      S_WAIT_DONE: begin
        if (bus.DP_DONE) begin
          w_capture    = 1'b1;
          w_next_state = S_FINISH;
        end else if (w_timeout) begin
          w_fail       = 1'b1;
          w_next_state = S_FINISH;
        end
      end
      S_FINISH: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase

    // abort overrides any done/timeout decision made above
    if (CMD_ABORT && w_in_run) begin
      w_abort      = 1'b1;
      w_capture    = 1'b0;
      w_fail       = 1'b0;
      w_idx_inc    = 1'b0;
      w_next_state = S_FINISH;
    end
  end

  // run bookkeeping: index, length, operands, wait counter and command status
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_index     <= '0;
      r_len       <= '0;
      r_wait_cnt  <= '0;
      r_dp_a      <= '0;
      r_dp_b      <= '0;
      r_result    <= '0;
      r_error     <= 1'b0;
      r_abort_clr <= 1'b0;
    end else begin
      if (w_start_run) begin
        r_len    <= CMD_LENGTH;
        r_index  <= '0;
        r_result <= '0;
        r_error  <= 1'b0;
      end
      if (w_start_short) begin
        r_result <= '0;
        r_error  <= w_short_err;
      end
      if (w_idx_inc) begin
        r_index <= r_index + IDX_W'(1);
      end
      if (r_state == S_LOAD) begin
        r_dp_a <= bus.MEM_A_RDATA;
        r_dp_b <= bus.MEM_B_RDATA;
      end
      if (r_state == S_WAIT_DONE) begin
        r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
      end else begin
        r_wait_cnt <= '0;
      end
      if (w_capture) begin
        r_result <= bus.DP_RESULT;
        r_error  <= 1'b0;
      end
      if (w_fail || w_abort) begin
        r_result <= '0;
        r_error  <= 1'b1;
      end
      r_abort_clr <= w_abort;
    end
  end

  // keeps the datapath cleared for as long as ARESET is being sampled high
  always_ff @(posedge ACLK) begin
    r_rst_hold <= ARESET;
  end

  assign CMD_BUSY   = (r_state != S_IDLE);
  assign CMD_DONE   = (r_state == S_FINISH);
  assign CMD_ERROR  = r_error;
  assign CMD_RESULT = r_result;

  assign bus.MEM_RD_EN        = (r_state == S_FETCH);
  assign bus.MEM_ADDR         = (r_state == S_FETCH) ? r_index[ADDR_BITS-1:0] : '0;
  assign bus.DP_A             = r_dp_a;
  assign bus.DP_B             = r_dp_b;
  assign bus.DP_VECTOR_LENGTH = r_len;
  // strobe and completion enable drop in the same cycle an abort is raised
  assign bus.DP_INPUTS_READY  = (r_state == S_STROBE)    && !CMD_ABORT;
  assign bus.DP_START         = (r_state == S_WAIT_DONE) && !CMD_ABORT;
  assign bus.DP_ARESETN       = !r_rst_hold &&
                                (r_state != S_CLEAR0) && (r_state != S_CLEAR1) &&
                                !((r_state == S_FINISH) && r_abort_clr);

endmodule

// File: tb/tb_dp_run_sequencer.sv
// Self-checking bench for dp_run_sequencer: behavioural operand memories and
// datapath, scoreboard of expected run outcomes checked at each CMD_DONE.
module tb_dp_run_sequencer;

  localparam int DW = 32;
  localparam int AB = 10;
  localparam int TO = 16;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic          CMD_START;
  logic [DW-1:0] CMD_LENGTH;
  logic          CMD_ABORT;
  logic          CMD_BUSY;
  logic          CMD_DONE;
  logic          CMD_ERROR;
  logic [DW-1:0] CMD_RESULT;

  dp_run_sequencer_if #(.DATA_WIDTH(DW), .ADDR_BITS(AB)) bus ();

  dp_run_sequencer #(
    .DATA_WIDTH     (DW),
    .ADDR_BITS      (AB),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .CMD_START  (CMD_START),
    .CMD_LENGTH (CMD_LENGTH),
    .CMD_ABORT  (CMD_ABORT),
    .CMD_BUSY   (CMD_BUSY),
    .CMD_DONE   (CMD_DONE),
    .CMD_ERROR  (CMD_ERROR),
    .CMD_RESULT (CMD_RESULT),
    .bus        (bus.master)
  );

  always #5 ACLK = ~ACLK;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // ---------------- operand memories (synchronous read) ----------------
  logic [7:0] mem_a [1024];
  logic [7:0] mem_b [1024];

  always @(posedge ACLK) begin
    if (bus.MEM_RD_EN === 1'b1) begin
      bus.MEM_A_RDATA <= mem_a[bus.MEM_ADDR];
      bus.MEM_B_RDATA <= mem_b[bus.MEM_ADDR];
    end
  end

  // ---------------- behavioural datapath ----------------
  logic [31:0] dp_acc  = '0;
  logic [31:0] dp_cnt  = '0;
  logic        dp_done = 1'b0;
  logic        dp_prev = 1'b0;
  logic        tie_off = 1'b0;

  always @(posedge ACLK) begin
    if (bus.DP_ARESETN !== 1'b1) begin
      dp_acc  <= '0;
      dp_cnt  <= '0;
      dp_done <= 1'b0;
      dp_prev <= 1'b0;
    end else begin
      dp_prev <= bus.DP_INPUTS_READY;
      if (bus.DP_INPUTS_READY && !dp_prev) begin
        dp_acc <= dp_acc + 32'(bus.DP_A) * 32'(bus.DP_B);
        dp_cnt <= dp_cnt + 1;
      end
      if (bus.DP_START && dp_cnt == bus.DP_VECTOR_LENGTH) dp_done <= 1'b1;
    end
  end

  assign bus.DP_RESULT = dp_acc;
  assign bus.DP_DONE   = dp_done & ~tie_off;

  // ---------------- cycle counter and event monitor ----------------
  int          cyc = 0;
  int          n_strobe = 0;
  int          n_rden = 0;
  int          n_done = 0;
  int          strobe_cyc [4096];
  int          done_cyc [64];
  logic [31:0] done_res [64];
  logic        done_err [64];
  logic        done_rstn [64];

  always @(posedge ACLK) cyc <= cyc + 1;

  always @(negedge ACLK) begin
    if (bus.DP_INPUTS_READY === 1'b1) begin
      if (n_strobe < 4096) strobe_cyc[n_strobe] = cyc;
      n_strobe++;
    end
    if (bus.MEM_RD_EN === 1'b1) n_rden++;
    if (CMD_DONE === 1'b1) begin
      if (n_done < 64) begin
        done_cyc[n_done]  = cyc;
        done_res[n_done]  = CMD_RESULT;
        done_err[n_done]  = CMD_ERROR;
        done_rstn[n_done] = bus.DP_ARESETN;
      end
      n_done++;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [31:0] res;
    logic        err;
    int          off;
    logic        clr;
  } exp_t;

  exp_t sb[$];
  int   t0 = 0;
  int   n_launched = 0;

  task automatic tick();
    @(negedge ACLK);
    #1;
  endtask

  function automatic logic [31:0] dot(input int n);
    logic [31:0] s = '0;
    for (int i = 0; i < n; i++) s += 32'(mem_a[i]) * 32'(mem_b[i]);
    return s;
  endfunction

  task automatic do_run(input string name, input int len, input int abort_at, input bit poke);
    exp_t e;
    int   base_s, base_r, base_d, exp_s, exp_r;
    bit   normal;
    normal = (len != 0) && (len <= 1024);
    if (!normal)            e = '{res: 32'd0, err: (len != 0), off: 1, clr: 1'b0};
    else if (abort_at > 0)  e = '{res: 32'd0, err: 1'b1, off: abort_at + 1, clr: 1'b1};
    else if (tie_off)       e = '{res: 32'd0, err: 1'b1, off: 3 + 4 * len + TO, clr: 1'b0};
    else                    e = '{res: dot(len), err: 1'b0, off: 5 + 4 * len, clr: 1'b0};
    exp_s = 0;
    exp_r = 0;
    if (normal) begin
      for (int k = 0; k < len; k++) begin
        if (abort_at == 0 || 5 + 4 * k < abort_at) exp_s++;
        if (abort_at == 0 || 3 + 4 * k < abort_at) exp_r++;
      end
    end
    tick();
    sb.push_back(e);
    n_launched++;
    base_s = n_strobe;
    base_r = n_rden;
    base_d = n_done;
    CMD_START  = 1'b1;
    CMD_LENGTH = DW'(len);
    t0 = cyc;
    tick();
    CMD_START = 1'b0;
    if (normal) begin
      check({name, "_vlen"}, bus.DP_VECTOR_LENGTH, len);
      check({name, "_aresetn_c1"}, bus.DP_ARESETN, 0);
      tick();
      check({name, "_aresetn_c2"}, bus.DP_ARESETN, 0);
    end
    for (int i = 0; i < 6000 && n_done == base_d; i++) begin
      if (abort_at > 0 && cyc - t0 == abort_at - 1) begin
        @(posedge ACLK);
        #1;
        check({name, "_strobe_pre_abort"}, bus.DP_INPUTS_READY, 1);
        CMD_ABORT = 1'b1;
        #1;
        check({name, "_strobe_drop"}, bus.DP_INPUTS_READY, 0);
        @(posedge ACLK);
        #1;
        CMD_ABORT = 1'b0;
      end
      tick();
      CMD_START = poke && (cyc - t0 == 6);
      if (CMD_START) CMD_LENGTH = DW'(1);
    end
    CMD_START = 1'b0;
    if (n_done == base_d) begin
      check({name, "_done_seen"}, 0, 1);
    end else begin
      e = sb.pop_front();
      check({name, "_result"}, done_res[base_d], e.res);
      check({name, "_error"}, done_err[base_d], e.err);
      check({name, "_done_cycle"}, done_cyc[base_d] - t0, e.off);
      check({name, "_aresetn_finish"}, done_rstn[base_d], !e.clr);
    end
    check({name, "_strobes"}, n_strobe - base_s, exp_s);
    check({name, "_rden"}, n_rden - base_r, exp_r);
    for (int i = 0; i < exp_s && base_s + i < n_strobe && base_s + i < 4096; i++)
      check({name, "_strobe_cycle"}, strobe_cyc[base_s + i] - t0, 5 + 4 * i);
  endtask

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1);
  end

  initial begin
    int base_d;
    ARESET     = 1'b1;
    CMD_START  = 1'b0;
    CMD_LENGTH = '0;
    CMD_ABORT  = 1'b0;
    foreach (mem_a[i]) begin
      mem_a[i] = '0;
      mem_b[i] = '0;
    end
    repeat (3) tick();
    check("rst_busy", CMD_BUSY, 0);
    check("rst_done", CMD_DONE, 0);
    check("rst_aresetn_held", bus.DP_ARESETN, 0);
    check("rst_result", CMD_RESULT, 0);
    ARESET = 1'b0;
    tick();
    check("rst_aresetn_release", bus.DP_ARESETN, 1);

    // N=3 basic run
    mem_a[0] = 1; mem_a[1] = 2; mem_a[2] = 3;
    mem_b[0] = 4; mem_b[1] = 5; mem_b[2] = 6;
    do_run("n3", 3, 0, 1'b0);
    check("n3_busy_in_finish", CMD_BUSY, 1);
    tick();
    check("n3_busy_fall", CMD_BUSY, 0);

    // back-to-back with an ignored start while busy
    mem_a[0] = 255; mem_a[1] = 255;
    mem_b[0] = 255; mem_b[1] = 255;
    do_run("b2b_n2", 2, 0, 1'b1);
    mem_a[0] = 7; mem_b[0] = 3;
    do_run("b2b_n1", 1, 0, 1'b0);

    // zero length and over-length
    do_run("n0", 0, 0, 1'b0);
    do_run("over", 1025, 0, 1'b0);

    // datapath never done
    tie_off = 1'b1;
    do_run("timeout", 2, 0, 1'b0);
    tie_off = 1'b0;

    // abort during STROBE of element 1, then a clean run
    mem_a[0] = 9;  mem_a[1] = 10; mem_a[2] = 11; mem_a[3] = 12;
    mem_b[0] = 11; mem_b[1] = 1;  mem_b[2] = 2;  mem_b[3] = 3;
    do_run("abort", 4, 9, 1'b0);
    do_run("post_abort", 1, 0, 1'b0);

    // maximum length
    foreach (mem_a[i]) begin
      mem_a[i] = 8'($urandom);
      mem_b[i] = 8'($urandom);
    end
    do_run("max", 1024, 0, 1'b0);

    // ARESET at cycle 8 of an N=4 run
    tick();
    base_d = n_done;
    CMD_START  = 1'b1;
    CMD_LENGTH = DW'(4);
    t0 = cyc;
    for (int i = 0; i < 8; i++) begin
      tick();
      CMD_START = 1'b0;
    end
    ARESET = 1'b1;
    tick();
    check("midrst_ctrl",
          {CMD_BUSY, CMD_DONE, CMD_ERROR, bus.MEM_RD_EN, bus.DP_ARESETN,
           bus.DP_INPUTS_READY, bus.DP_START}, 0);
    check("midrst_result", CMD_RESULT, 0);
    check("midrst_vlen", bus.DP_VECTOR_LENGTH, 0);
    check("midrst_ops", {bus.DP_A, bus.DP_B, bus.MEM_ADDR}, 0);
    ARESET = 1'b0;
    tick();
    check("midrst_aresetn_back", bus.DP_ARESETN, 1);
    check("midrst_idle", CMD_BUSY, 0);
    repeat (40) tick();
    check("midrst_no_done", n_done - base_d, 0);
    mem_a[0] = 6; mem_b[0] = 7;
    do_run("post_reset", 1, 0, 1'b0);

    check("total_dones", n_done, n_launched);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dp_run_sequencer.md
# dp_run_sequencer

Command-level controller for the 8-bit dot-product datapath. On a start command it clears the datapath and reads operand pairs from two synchronous-read element memories. It presents each pair with a single `inputs_ready` strobe, then releases `DP_START`, waits for `DP_DONE` and returns the captured result. It sits between the AXI register block (command side) and the dot-product datapath plus its two operand buffers (memory side).

## Interface
- `DATA_WIDTH`, default 32: width of length, result and datapath length/result ports.
- `ADDR_BITS`, default 10: operand memory address width; max vector length 2^ADDR_BITS.
- `TIMEOUT_CYCLES`, default 16: cycles allowed in WAIT_DONE before error.
- `ACLK` in 1: clock; all logic on rising edge.
- `ARESET` in 1: reset, synchronous, active-high.
- `CMD_START` in 1: start pulse, sampled only in IDLE.
- `CMD_LENGTH` in DATA_WIDTH: vector length, latched at accepted start.
- `CMD_ABORT` in 1: abort the current run (ignored in IDLE).
- `CMD_BUSY` out 1: high in every state except IDLE.
- `CMD_DONE` out 1: one-cycle completion pulse.
- `CMD_ERROR` out 1: status of the last run, valid with `CMD_DONE`, held until the next accepted start.
- `CMD_RESULT` out DATA_WIDTH: result of the last run, held until the next accepted start.
- `MEM_RD_EN` out 1: operand memory read enable.
- `MEM_ADDR` out ADDR_BITS: element index to both memories.
- `MEM_A_RDATA` in 8: A element, valid the cycle after `MEM_RD_EN`.
- `MEM_B_RDATA` in 8: B element, same timing as A.
- `DP_ARESETN` out 1: active-low clear to the datapath.
- `DP_A` out 8: operand A to the datapath.
- `DP_B` out 8: operand B to the datapath.
- `DP_INPUTS_READY` out 1: operand strobe to the datapath.
- `DP_VECTOR_LENGTH` out DATA_WIDTH: latched length.
- `DP_START` out 1: datapath completion enable.
- `DP_RESULT` in DATA_WIDTH: datapath result.
- `DP_DONE` in 1: datapath done; sticky until the datapath is cleared.

## Operation
- States: IDLE, CLEAR0, CLEAR1, FETCH, LOAD, STROBE, GAP, WAIT_DONE, FINISH.
- **IDLE**
  - `CMD_START`=1 with length 0: go to FINISH with result 0, error 0. No datapath or memory activity.
  - `CMD_START`=1 with length > 2^ADDR_BITS: go to FINISH with result 0, error 1.
  - `CMD_START`=1 otherwise: latch the length, clear the index, go to CLEAR0.
- **CLEAR0, CLEAR1:** `DP_ARESETN`=0. This clears the datapath accumulator, counter and sticky done. Then go to FETCH.
- **FETCH:** `MEM_RD_EN`=1, `MEM_ADDR`=index.
- **LOAD:** register `MEM_A_RDATA` into `DP_A` and `MEM_B_RDATA` into `DP_B`.
- **STROBE:** `DP_INPUTS_READY`=1. This is the only state driving it high, so every element produces exactly one rising edge.
- **GAP:** `DP_INPUTS_READY`=0.
  - If index == length−1, go to WAIT_DONE.
  - Otherwise increment the index and go to FETCH.
- **WAIT_DONE:** `DP_START`=1, with a cycle counter starting at 0.
  - `DP_DONE`=1: capture `DP_RESULT` into `CMD_RESULT`, set error 0, go to FINISH.
  - Counter reaches TIMEOUT_CYCLES: set result 0, error 1, go to FINISH.
- **FINISH:** `CMD_DONE`=1 for one cycle, then go to IDLE.
- **Abort:** `CMD_ABORT`=1 in any of CLEAR0 through WAIT_DONE:
  - next state is FINISH with error 1 and result 0;
  - `DP_ARESETN` is driven 0 during FINISH;
  - `DP_START` and `DP_INPUTS_READY` drop immediately.
- **Abort vs. done:** abort wins over a simultaneous `DP_DONE` or timeout.
- **Operand stability:** `DP_A` and `DP_B` change only in LOAD, so they are stable from STROBE until the next LOAD (at least 3 cycles).
- **`DP_VECTOR_LENGTH`:** updates only on an accepted start.
- **Outputs outside their states:** `MEM_RD_EN`, `DP_INPUTS_READY` and `DP_START` are 0 in all other states.
- **Reset** (`ARESET`=1, any state, including mid-run):
  - state goes to IDLE;
  - all outputs go to 0, including `DP_ARESETN`=0, so the datapath is held cleared;
  - `DP_ARESETN` returns to 1 in the first cycle after `ARESET` deasserts.

## Timing
- Cycle 0 is the IDLE cycle in which `CMD_START` is sampled.
- CLEAR0 and CLEAR1 occupy cycles 1–2.
- Element k (0-based):
  - FETCH at 3+4k;
  - LOAD at 4+4k;
  - STROBE at 5+4k;
  - GAP at 6+4k.
- WAIT_DONE is entered at cycle 3+4N.
- With the team datapath:
  - `DP_DONE` is seen at 4+4N;
  - `CMD_DONE` pulses at 5+4N with `CMD_RESULT` valid;
  - `CMD_BUSY` falls at 6+4N.
- Zero-length or over-length start: `CMD_DONE` pulses at cycle 1.
- Back-to-back operation: `CMD_START` is accepted again in the first IDLE cycle after FINISH. `CMD_START` while busy is ignored (not queued).
- Arithmetic: the index is ADDR_BITS+1 bits wide, so the compare against length−1 is correct at the maximum length. The length compare uses the full DATA_WIDTH.

## Test plan
- **N=3, A=[1,2,3], B=[4,5,6]:**
  - `CMD_DONE` at cycle 17 with `CMD_RESULT`=32, `CMD_ERROR`=0;
  - exactly 3 `DP_INPUTS_READY` pulses, at cycles 5, 9 and 13.
- **Back-to-back runs:** N=2 ([255,255]·[255,255]) then N=1 ([7]·[3]):
  - results 130050 then 21, showing the datapath was cleared between runs;
  - `DP_ARESETN` low in cycles 1–2 of each run.
- **Zero length (N=0):** `CMD_DONE` at cycle 1, result 0, error 0, no `MEM_RD_EN` and no strobes.
- **Datapath never done:** tie `DP_DONE`=0 with N=2.
  - Timeout after 16 WAIT_DONE cycles: error 1, result 0.
  - Over-length check: N=1025 with ADDR_BITS=10 gives error 1 at cycle 1.
- **Abort during STROBE of element 1 (N=4):** FINISH next cycle with error 1 and `DP_ARESETN`=0 in FINISH. A subsequent N=1 run returns the correct product.
- **`ARESET` mid-run:** assert at cycle 8 of an N=4 run. Next cycle all outputs are 0 and the state is IDLE; `CMD_DONE` never pulses for that run.
